port_queue: RTL and testbench
=============================

Name: port_queue

Overview:
- Per-output-port payload buffer between the input-port deframer and the output-port serializer.
- Watches the deframer's decoded-packet strobe and captures the 32-bit payload when the destination address matches this port.
- Holds captured payloads in a show-ahead FIFO and presents the head word to the serializer with a ready/pop handshake.
- Counts packets discarded on overflow.

Parameters:
- PORT_ID, 7, 3-bit destination port number this queue serves (0..7).
- DEPTH, 8, FIFO entries; power of two, 2..64.
- WIDTH, 32, payload width in bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- vld  input  1  one-cycle strobe from deframer: addr/payload valid this cycle.
- addr  input  4  destination address from deframer; [2:0] port number, [3] must be 0.
- payload  input  WIDTH  packet payload from deframer.
- pop  input  1  serializer consumed head word this cycle.
- dout  output  WIDTH  head-of-queue payload (show-ahead).
- rdy  output  1  queue non-empty; dout is valid.
- full  output  1  count == DEPTH.
- count  output  log2(DEPTH)+1  current occupancy.
- drop_cnt  output  8  packets dropped on overflow, saturating.

Behaviour:
- Reset, sampled on the clock edge with reset_n=0:
  - clears wr_ptr, rd_ptr, count and drop_cnt.
  - Outputs become rdy=0, full=0, count=0, drop_cnt=0, dout=0.
  - Reset mid-operation discards all queued data; the memory contents are not cleared.
  - dout reads 0 whenever rdy=0; it is gated by rdy.
- Match:
  - hit = vld && addr[3]==0 && addr[2:0]==PORT_ID.
  - vld with a non-matching or addr[3]=1 address is ignored and does not count as a drop.
- Accept:
  - push = hit && (count<DEPTH || pop_ok), where pop_ok = pop && rdy.
  - On push, mem[wr_ptr] <= payload and wr_ptr increments, wrapping modulo DEPTH.
- Pop:
  - pop_ok advances rd_ptr, wrapping modulo DEPTH.
  - pop while rdy=0 is ignored with no pointer or count change.
- Count:
  - +1 on push only, -1 on pop_ok only, unchanged when both occur.
- Latency and outputs:
  - A word pushed at edge N drives rdy=1 with dout=that word from edge N onward when the queue was empty, i.e. visible in the cycle after the vld cycle.
  - rdy, full and dout are decoded from registered pointers and count only; there is no combinational path from vld or pop to any output.
- Simultaneous push+pop when empty:
  - pop is ignored (rdy=0); the push proceeds.
- Simultaneous push+pop when full:
  - Both proceed; count stays DEPTH and full stays 1.
  - The new word lands in the slot being freed (wr_ptr==rd_ptr), and mem is written after the head is read at that edge.
- Overflow:
  - hit && count==DEPTH && !pop_ok drops the packet.
  - drop_cnt increments, saturating at 255 (holds at 255 on further drops).
  - FIFO state is unchanged on a drop.
- Wrap-around:
  - Pointers are log2(DEPTH) bits; full/empty come from count, never from pointer compare.
- No X propagation: every register has a defined reset value except mem.

Test Plan:
- Reset, then vld=1 addr=4'h7 payload=32'hDEADBEEF (PORT_ID=7) -> next cycle rdy=1, dout=32'hDEADBEEF, count=1; pop one cycle -> rdy=0, count=0, dout=0.
- vld with addr=4'h3, then addr=4'hF, payload=32'h12345678 -> rdy stays 0, count=0, drop_cnt=0.
- 8 matching pushes of 1..8 with no pop -> full=1, count=8; 9th push of 32'h9 -> drop_cnt=1, count=8; pop 8 times -> dout sequence 1..8 in order, then rdy=0.
- Queue full with heads 1..8, push 32'hAA and pop in the same cycle -> count=8, next dout=2; after 7 more pops, dout=32'hAA (wrap-around verified).
- Empty queue, push 32'h55 and pop in the same cycle -> pop ignored, count=1, dout=32'h55.
- 300 matching pushes while full -> drop_cnt=255, holding; reset_n=0 for one edge with 5 queued -> rdy=0, count=0, drop_cnt=0, and the next push reappears as dout one cycle later.

Source files
------------

// File: rtl/port_queue.sv
// port_queue: per-port show-ahead payload FIFO with address match and saturating drop counter
module port_queue #(
  parameter logic [2:0] PORT_ID = 3'd7,
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     vld,
  input  logic [3:0]               addr,
  input  logic [WIDTH-1:0]         payload,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     rdy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic hit, pop_ok, push, drop;
  always_comb begin
    rdy = count != '0;
    full = count == FULL_CNT;
    dout = rdy ? mem[rd_ptr] : '0;
    hit = vld && addr == {1'b0, PORT_ID};
    pop_ok = pop && rdy;
    push = hit && (!full || pop_ok);
    drop = hit && full && !pop_ok;
  end
  // Head is read combinationally before this edge's write, so a full-queue push+pop into the freed slot is safe.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= payload;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count <= (push && !pop_ok) ? count + 1'b1 : (pop_ok && !push) ? count - 1'b1 : count;
      drop_cnt <= (drop && drop_cnt != 8'hFF) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_port_queue.sv
// tb_port_queue: vector table, corner sequences and random traffic against a queue-based model
module tb_port_queue;
  logic clock = 0, reset_n = 0, vld = 0, pop = 0;
  logic [3:0] addr = '0;
  logic [31:0] payload = '0;
  logic [31:0] dout;
  logic rdy, full;
  logic [3:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  int drops = 0;

  port_queue #(.PORT_ID(3'd7), .DEPTH(8), .WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .vld(vld), .addr(addr), .payload(payload), .pop(pop),
    .dout(dout), .rdy(rdy), .full(full), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [31:0] p, input logic po);
    int sz;
    bit hit, pok;
    reset_n = r; vld = v; addr = a; payload = p; pop = po;
    @(posedge clock);
    sz = q.size();
    if (!r) begin
      q.delete();
      drops = 0;
    end else begin
      hit = v && a == 4'h7;
      pok = po && sz > 0;
      if (pok) void'(q.pop_front());
      if (hit && (sz < 8 || pok)) q.push_back(p);
      else if (hit) drops = drops < 255 ? drops + 1 : 255;
    end
    #1;
    chk("model_rdy", rdy, q.size() > 0);
    chk("model_dout", dout, q.size() > 0 ? q[0] : 32'h0);
    chk("model_count", count, q.size());
    chk("model_full", full, q.size() == 8);
    chk("model_drop", drop_cnt, drops);
  endtask

  typedef struct {
    logic r, v;
    logic [3:0] a;
    logic [31:0] p;
    logic po;
    logic e_rdy;
    logic [31:0] e_dout;
    logic [3:0] e_cnt;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 4'h7, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 4'd1, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        4'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 4'h3, 32'h12345678, 1'b0, 1'b0, 32'h0,        4'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h0,        4'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        4'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 4'h7, 32'h55,       1'b1, 1'b1, 32'h55,       4'd1, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 4'h7, 32'h66,       1'b0, 1'b1, 32'h55,       4'd1, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0,        4'd0, 8'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].p, tbl[i].po);
      chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].e_drop);
    end

    for (int i = 1; i <= 8; i++) step(1, 1, 4'h7, i, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    step(1, 1, 4'h7, 32'h9, 0);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_count", count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_dout%0d", i), dout, i);
      step(1, 0, 4'h0, 0, 1);
    end
    chk("drain_rdy", rdy, 0);

    for (int i = 1; i <= 8; i++) step(1, 1, 4'h7, i, 0);
    step(1, 1, 4'h7, 32'hAA, 1);
    chk("pp_full_count", count, 8);
    chk("pp_full_flag", full, 1);
    chk("pp_full_dout", dout, 2);
    for (int i = 0; i < 7; i++) step(1, 0, 4'h0, 0, 1);
    chk("wrap_dout", dout, 32'hAA);
    step(1, 0, 4'h0, 0, 1);
    chk("wrap_empty", rdy, 0);

    for (int i = 1; i <= 8; i++) step(1, 1, 4'h7, i, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 4'h7, 32'hF00 + i, 0);
    chk("sat_drop", drop_cnt, 255);
    for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 0, 1);
    chk("pre_rst_count", count, 5);
    step(0, 0, 4'h0, 0, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_dout", dout, 0);
    step(1, 1, 4'h7, 32'h77, 0);
    chk("post_rst_rdy", rdy, 1);
    chk("post_rst_dout", dout, 32'h77);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      a = ($urandom_range(0, 2) != 0) ? 4'h7 : 4'($urandom);
      step(($urandom_range(0, 299) != 0), $urandom_range(0, 1), a, $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
